// File: rtl/intmul_sched_pkg.sv
// Shared types and helpers for the round-robin multiplier scheduler.
//   sched_state_t           : RUN / DRAIN / HALT scheduler states
//   sched_tag_t             : {vld, id} tag carried alongside each product
//   intmul_wrapper_params_t : multiplier configuration record
//   intmul_wrapper_lat()    : pipeline depth of a multiplier configuration
//   rr_next()               : round-robin pick (first valid after ptr, wrapping)
package intmul_sched_pkg;

    // Upper bounds for NREQ (2..16); tags are sized for the worst case and
    // the scheduler keeps only the low IDW bits meaningful.
    localparam int MAX_REQ = 16;
    localparam int MAX_IDW = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic               vld;
        logic [MAX_IDW-1:0] id;
    } sched_tag_t;

    typedef struct packed {
        int loga;
        int logb;
        int ff_in;
        int ff_mul;
        int ff_out;
        int use_csa;
        int ff_csa;
        int more_dsp;
        int non_std;
    } intmul_wrapper_params_t;

    // One cycle per enabled register stage; the CSA register only exists
    // when the CSA tree itself is in use.
    function automatic int intmul_wrapper_lat(input intmul_wrapper_params_t p);
        int lat;
        lat = 0;
        if (p.ff_in  != 0) lat++;
        if (p.ff_mul != 0) lat++;
        if (p.ff_out != 0) lat++;
        if (p.use_csa != 0 && p.ff_csa != 0) lat++;
        return lat;
    endfunction

    // Returns the first index with valid set, searching ptr+1, ptr+2, ...
    // modulo n; -1 when nothing is valid. Iterating downwards lets the
    // closest candidate overwrite farther ones.
    function automatic int rr_next(input logic [MAX_REQ-1:0] valid,
                                   input logic [MAX_IDW-1:0] ptr,
                                   input int n);
        int idx;
        int res;
        res = -1;
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                idx = (int'(ptr) + k) % n;
                if (valid[idx[MAX_IDW-1:0]]) res = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/intmul_wrapper.sv
// Pipelined unsigned multiplier, c = a * b, full LOGA+LOGB width.
// Result for operands presented in cycle t appears in cycle t+LAT, where
// LAT = intmul_wrapper_lat() of the parameter set. Data registers are not
// reset.
//   clk : clock
//   i_a : operand A (LOGA bits)
//   i_b : operand B (LOGB bits)
//   o_c : product (LOGA+LOGB bits)
module intmul_wrapper
    import intmul_sched_pkg::*;
#(
    parameter int LOGA     = 64,
    parameter int LOGB     = 64,
    parameter int FF_IN    = 1,
    parameter int FF_MUL   = 1,
    parameter int FF_OUT   = 1,
    parameter int USE_CSA  = 0,
    parameter int FF_CSA   = 0,
    parameter int MORE_DSP = 0,
    parameter int NON_STD  = 0
) (
    input  logic                 clk,
    input  logic [LOGA-1:0]      i_a,
    input  logic [LOGB-1:0]      i_b,
    output logic [LOGA+LOGB-1:0] o_c
);

    localparam intmul_wrapper_params_t P = '{
        loga: LOGA, logb: LOGB, ff_in: FF_IN, ff_mul: FF_MUL, ff_out: FF_OUT,
        use_csa: USE_CSA, ff_csa: FF_CSA, more_dsp: MORE_DSP, non_std: NON_STD
    };
    localparam int LAT = intmul_wrapper_lat(P);
    localparam int W   = LOGA + LOGB;

    logic [W-1:0] w_prod;
    logic [W-1:0] r_pipe [LAT];

    assign w_prod = {{LOGB{1'b0}}, i_a} * {{LOGA{1'b0}}, i_b};

    // Retiming across the stages is left to the synthesis tool.
    always_ff @(posedge clk) begin
        r_pipe[0] <= w_prod;
        for (int k = 1; k < LAT; k++) begin
            r_pipe[k] <= r_pipe[k-1];
        end
    end

    assign o_c = r_pipe[LAT-1];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   i_valid : request vector (N bits)
//   i_ptr   : last granted index; search starts at i_ptr+1 and wraps
//   o_grant : one-hot grant, zero when nothing is valid
//   o_idx   : index of the granted requester (0 when none)
//   o_any   : some requester is granted
module rr_arbiter
    import intmul_sched_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   i_valid,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_grant,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);

    int w_sel;

    always_comb begin
        w_sel   = rr_next(MAX_REQ'(i_valid), MAX_IDW'(i_ptr), N);
        o_any   = (w_sel >= 0);
        o_idx   = '0;
        o_grant = '0;
        if (o_any) begin
            o_idx          = IDW'(w_sel);
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/intmul_rr_sched.sv
// Round-robin scheduler sharing one pipelined intmul_wrapper between NREQ
// requesters. At most one operand pair is issued per cycle; its product comes
// back exactly LAT cycles later tagged with the requester id. drain_req stops
// granting and, once the pipe is empty, parks the block in HALT (idle=1).
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester operand valid
//   req_ready  : per-requester grant, one-hot or zero
//   req_a/b    : packed operands, slot i at [i*LOGA +: LOGA] / [i*LOGB +: LOGB]
//   rsp_valid  : product valid (single cycle, no backpressure)
//   rsp_id     : requester index of the product
//   rsp_c      : unsigned product A*B
//   drain_req  : level-sensitive stop request
//   idle       : halted with the pipeline empty
//   inflight   : products currently inside the multiplier
module intmul_rr_sched
    import intmul_sched_pkg::*;
#(
    parameter  int NREQ     = 4,
    parameter  int LOGA     = 64,
    parameter  int LOGB     = 64,
    parameter  int FF_IN    = 1,
    parameter  int FF_MUL   = 1,
    parameter  int FF_OUT   = 1,
    parameter  int USE_CSA  = 0,
    parameter  int FF_CSA   = 0,
    parameter  int MORE_DSP = 0,
    parameter  int NON_STD  = 0,
    localparam int IDW      = $clog2(NREQ),
    localparam intmul_wrapper_params_t WP = '{
        loga: LOGA, logb: LOGB, ff_in: FF_IN, ff_mul: FF_MUL, ff_out: FF_OUT,
        use_csa: USE_CSA, ff_csa: FF_CSA, more_dsp: MORE_DSP, non_std: NON_STD
    },
    localparam int LAT      = intmul_wrapper_lat(WP),
    localparam int CNTW     = $clog2(LAT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*LOGA-1:0] req_a,
    input  logic [NREQ*LOGB-1:0] req_b,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [LOGA+LOGB-1:0] rsp_c,
    input  logic                 drain_req,
    output logic                 idle,
    output logic [CNTW-1:0]      inflight
);

    if (LAT < 1) begin : g_lat_chk
        $error("intmul_rr_sched: multiplier latency must be at least 1");
    end
    if (NREQ < 2 || NREQ > MAX_REQ) begin : g_nreq_chk
        $error("intmul_rr_sched: NREQ must be in 2..16");
    end

    sched_state_t    r_state, w_state_next;
    logic [IDW-1:0]  r_ptr;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gidx;
    logic            w_any;
    logic            w_allow;
    logic            w_issue;
    logic [LOGA-1:0] w_a;
    logic [LOGB-1:0] w_b;
    sched_tag_t      r_tag [LAT];
    logic [CNTW-1:0] r_inflight;
    logic            w_unused_tag;

    rr_arbiter #(.N(NREQ)) u_arb (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    // drain_req blocks the grant in the very cycle it is first seen, so
    // nothing new slips in while the state register is still RUN.
    assign w_allow   = (r_state == RUN) && !drain_req && !rst;
    assign req_ready = w_allow ? w_grant : '0;
    assign w_issue   = w_allow && w_any;

    // Operands of the granted slot go straight into the multiplier.
    assign w_a = req_a[w_gidx*LOGA +: LOGA];
    assign w_b = req_b[w_gidx*LOGB +: LOGB];

    intmul_wrapper #(
        .LOGA(LOGA), .LOGB(LOGB), .FF_IN(FF_IN), .FF_MUL(FF_MUL), .FF_OUT(FF_OUT),
        .USE_CSA(USE_CSA), .FF_CSA(FF_CSA), .MORE_DSP(MORE_DSP), .NON_STD(NON_STD)
    ) u_mul (
        .clk (clk),
        .i_a (w_a),
        .i_b (w_b),
        .o_c (rsp_c)
    );

    // Tag pipe runs in lockstep with the multiplier: the tag entered with an
    // issue emerges at the last stage together with its product.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0] <= '{vld: w_issue, id: MAX_IDW'(w_gidx)};
            for (int k = 1; k < LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    assign rsp_valid    = r_tag[LAT-1].vld;
    assign rsp_id       = r_tag[LAT-1].id[IDW-1:0];
    assign w_unused_tag = ^{1'b0, r_tag[LAT-1].id};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= IDW'(NREQ - 1);
        end else if (w_issue) begin
            r_ptr <= w_gidx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue, rsp_valid})
                2'b10:   r_inflight <= r_inflight + CNTW'(1);
                2'b01:   r_inflight <= r_inflight - CNTW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign inflight = r_inflight;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(r_inflight == '0 && rsp_valid && !w_issue));
            assert (!(r_inflight == CNTW'(LAT) && w_issue && !rsp_valid));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // HALT is only entered once the last product has left the pipe, so
    // idle can be taken straight from the state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN: begin
                if (drain_req) w_state_next = DRAIN;
            end
            DRAIN: begin
                if (!drain_req) begin
                    w_state_next = RUN;
                end else if (r_inflight == '0 && !rsp_valid) begin
                    w_state_next = HALT;
                end
            end
            HALT: begin
                if (!drain_req) w_state_next = RUN;
            end
            default: w_state_next = RUN;
        endcase
    end

    assign idle = (r_state == HALT);

endmodule

// File: tb/tb_intmul_rr_sched.sv
module tb_intmul_rr_sched;

    localparam int NREQ = 4;
    localparam int LAT  = 3;   // three register stages with default parameters
    localparam int S_RUN = 0, S_DRAIN = 1, S_HALT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*64-1:0]   req_a;
    logic [NREQ*64-1:0]   req_b;
    logic                 rsp_valid;
    logic [1:0]           rsp_id;
    logic [127:0]         rsp_c;
    logic                 drain_req;
    logic                 idle;
    logic [1:0]           inflight;

    intmul_rr_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_c     (rsp_c),
        .drain_req (drain_req),
        .idle      (idle),
        .inflight  (inflight)
    );

    // Reference model: a queue of expected products with their due cycle,
    // the round-robin pointer and the drain state.
    typedef struct {
        longint       due;
        int           id;
        logic [127:0] c;
    } exp_t;

    exp_t         q[$];
    int           ptr;
    int           st;
    longint       cyc;
    logic         pend [NREQ];
    logic [63:0]  pa [NREQ];
    logic [63:0]  pb [NREQ];

    int total = 0;
    int bad   = 0;

    logic [NREQ-1:0] seen_ready;
    logic            seen_rv;
    logic [1:0]      seen_id;
    logic [127:0]    seen_c;
    logic            seen_idle;
    logic [1:0]      seen_infl;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic post(input int i, input logic [63:0] a, input logic [63:0] b);
        pend[i] = 1'b1;
        pa[i]   = a;
        pb[i]   = b;
    endtask

    function automatic logic [63:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return '1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // One clock cycle: drive, check at negedge, advance the model at posedge.
    task automatic step();
        int              g;
        int              occ;
        logic            exp_rv;
        logic [NREQ-1:0] exp_ready;
        logic [127:0]    prod;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = pend[i];
            req_a[i*64 +: 64]  = pa[i];
            req_b[i*64 +: 64]  = pb[i];
        end
        @(negedge clk);
        seen_ready = req_ready;
        seen_rv    = rsp_valid;
        seen_id    = rsp_id;
        seen_c     = rsp_c;
        seen_idle  = idle;
        seen_infl  = inflight;
        g = -1;
        if (!rst && st == S_RUN && !drain_req) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (g < 0 && pend[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 128'(req_ready), 128'(exp_ready));
        occ    = q.size();
        exp_rv = (occ > 0) && (q[0].due == cyc);
        if (!rst) begin
            check("rsp_valid", 128'(rsp_valid), 128'(exp_rv));
            if (exp_rv) begin
                check("rsp_id", 128'(rsp_id), 128'(q[0].id));
                check("rsp_c", rsp_c, q[0].c);
                $display("rsp cyc=%0d id=%0d c=%h", cyc, rsp_id, rsp_c);
            end
            check("idle", 128'(idle), 128'(st == S_HALT));
            check("inflight", 128'(inflight), 128'(occ));
        end
        @(posedge clk);
        if (rst) begin
            ptr = NREQ - 1;
            st  = S_RUN;
            q.delete();
        end else begin
            if (exp_rv) void'(q.pop_front());
            if (g >= 0) begin
                prod = {64'd0, pa[g]} * {64'd0, pb[g]};
                q.push_back('{due: cyc + LAT, id: g, c: prod});
                ptr     = g;
                pend[g] = 1'b0;
            end
            case (st)
                S_RUN:   if (drain_req) st = S_DRAIN;
                S_DRAIN: if (!drain_req) st = S_RUN;
                         else if (occ == 0 && !exp_rv) st = S_HALT;
                default: if (!drain_req) st = S_RUN;
            endcase
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic flush(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int rsp_cnt;
        int zero_k;
        int idle_k;
        logic [NREQ-1:0] rr_exp [5];
        logic [NREQ-1:0] wrap_exp [4];
        rr_exp   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        wrap_exp = '{4'b1000, 4'b0001, 4'b1000, 4'b0001};

        rst = 1'b1; drain_req = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; end
        ptr = NREQ - 1; st = S_RUN; cyc = 0;
        step();
        step();
        rst = 1'b0;

        // reset state
        step();
        check("reset_rsp_valid", 128'(seen_rv), 128'(0));
        check("reset_rsp_id", 128'(seen_id), 128'(0));
        check("reset_idle", 128'(seen_idle), 128'(0));
        check("reset_inflight", 128'(seen_infl), 128'(0));

        // single request from requester 2
        post(2, 64'd3, 64'd5);
        step();
        check("single_ready", 128'(seen_ready), 128'(4'b0100));
        for (int k = 1; k <= LAT; k++) begin
            step();
            check("single_rv", 128'(seen_rv), 128'(k == LAT));
        end
        check("single_id", 128'(seen_id), 128'(2));
        check("single_c", seen_c, 128'd15);
        flush(2);

        // all requesters valid from reset
        do_reset();
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < NREQ; i++) if (!pend[i]) post(i, rnd_op(), rnd_op());
            step();
            check("rr_seq", 128'(seen_ready), 128'(rr_exp[k]));
        end
        flush(LAT + NREQ + 2);

        // wrap-around between requesters 3 and 0
        do_reset();
        post(3, rnd_op(), rnd_op());
        for (int k = 0; k < 4; k++) begin
            step();
            check("wrap_seq", 128'(seen_ready), 128'(wrap_exp[k]));
            if (!pend[0]) post(0, rnd_op(), rnd_op());
            if (!pend[3]) post(3, rnd_op(), rnd_op());
        end
        pend[0] = 1'b0; pend[3] = 1'b0;
        flush(LAT + 2);

        // full-width product
        post(1, '1, '1);
        step();
        flush(LAT - 1);
        step();
        check("full_rv", 128'(seen_rv), 128'(1));
        check("full_c", seen_c, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        flush(2);

        // drain after three issues
        do_reset();
        for (int i = 0; i < NREQ; i++) post(i, rnd_op(), rnd_op());
        flush(3);
        drain_req = 1'b1;
        rsp_cnt = 0; zero_k = -1; idle_k = -1;
        for (int k = 0; k < LAT + 6; k++) begin
            step();
            check("drain_no_grant", 128'(seen_ready), 128'(0));
            if (seen_rv) rsp_cnt++;
            if (zero_k < 0 && seen_infl == 2'd0) zero_k = k;
            if (idle_k < 0 && seen_idle) idle_k = k;
        end
        check("drain_rsp_cnt", 128'(rsp_cnt), 128'(3));
        check("drain_idle_lag", 128'(idle_k - zero_k), 128'(1));
        drain_req = 1'b0;
        step();
        check("release_idle_hold", 128'(seen_idle), 128'(1));
        check("release_no_grant", 128'(seen_ready), 128'(0));
        step();
        check("release_idle", 128'(seen_idle), 128'(0));
        check("release_grant", 128'(seen_ready), 128'(4'b1000));
        flush(LAT + 2);

        // reset while the pipe is full
        for (int k = 0; k < LAT; k++) begin
            for (int i = 0; i < NREQ; i++) if (!pend[i]) post(i, rnd_op(), rnd_op());
            step();
        end
        for (int i = 0; i < NREQ; i++) if (!pend[i]) post(i, rnd_op(), rnd_op());
        rst = 1'b1;
        step();
        check("full_inflight", 128'(seen_infl), 128'(LAT));
        rst = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            step();
            check("rst_no_rsp", 128'(seen_rv), 128'(0));
            if (k == 1) begin
                check("rst_inflight", 128'(seen_infl), 128'(0));
                check("rst_first_grant", 128'(seen_ready), 128'(4'b0001));
            end
        end
        flush(2 * NREQ + LAT);

        // randomized traffic with occasional drain and reset
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NREQ; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1) post(i, rnd_op(), rnd_op());
            if ($urandom_range(0, 14) == 0) drain_req = ~drain_req;
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        drain_req = 1'b0;
        flush(2 * NREQ + LAT + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
